button_conditioner: RTL and testbench
=====================================

# button_conditioner

Four-channel push-button conditioner that sits directly upstream of the sprite/block controller and drives its up/down/left/right inputs. Each raw board button is synchronized, then debounced by its own state machine. The block produces a debounced level, a single-cycle press pulse, a priority-resolved one-hot held direction, and a latched last-pressed direction. All logic runs in the master clock domain.

## Interface
- DEBOUNCE_CYCLES, 1000000, stable-input cycles required to accept a press or release (≥2)
- CNT_W, 20, debounce counter width; 2^CNT_W ≥ DEBOUNCE_CYCLES
- clk  input  1  master clock; all flops on rising edge
- rst  input  1  reset, asynchronous, active-high
- btn_raw  input  4  raw buttons, asynchronous: [0]=up [1]=down [2]=left [3]=right
- btn_db  output  4  debounced level per button
- btn_pulse  output  4  one-cycle pulse per accepted press
- dir_held  output  4  one-hot held direction, same bit order; priority right>left>up>down; 0 when none held
- dir_last  output  4  one-hot most recently pressed direction; holds until next press

## Operation
- Synchronizer: 2 flops per bit (sync1, sync2); the FSM samples only sync2 (s).
- Per-channel FSM with states and independent CNT_W-bit counter:
  - IDLE: if s=1, go to WAIT_P and clear the counter.
  - WAIT_P: if s=0, go to IDLE and clear the counter. If the counter equals DEBOUNCE_CYCLES-1, go to PRESSED and set btn_pulse for one cycle. Otherwise increment the counter.
  - PRESSED: if s=0, go to WAIT_R and clear the counter.
  - WAIT_R: if s=1, go back to PRESSED with no pulse. If the counter equals DEBOUNCE_CYCLES-1, go to IDLE. Otherwise increment the counter.
- btn_db = 1 in PRESSED or WAIT_R, decoded from the state register (glitch-free).
- btn_pulse is a registered bit. It is set only on the WAIT_P→PRESSED edge and cleared the following cycle.
- dir_held: combinational from btn_db.
  - The highest-priority held bit wins; lower bits are masked.
  - Example: btn_db=4'b1111 gives 4'b1000; btn_db=4'b0011 gives 4'b0001.
- dir_last register:
  - Loaded with the priority-resolved one-hot of btn_pulse on any cycle where btn_pulse≠0.
  - Otherwise holds its value.
  - Simultaneous pulses resolve with the same priority.
- Counter never wraps. It is compared at DEBOUNCE_CYCLES-1 and cleared on every state entry.

## Timing
- Reset, asynchronous:
  - Sync flops 0, all FSMs IDLE, counters 0.
  - btn_db=0, btn_pulse=0, dir_held=0, dir_last=0.
  - All outputs drop immediately, including mid-debounce or mid-press.
- Edge numbering: edge 1 is the first rising edge that samples btn_raw=1 into sync1.
- Press latency, with raw held steady:
  - Edge 2: sync2=1.
  - Edge 3: IDLE→WAIT_P.
  - Edge D+3 (D = DEBOUNCE_CYCLES): WAIT_P→PRESSED. btn_db, btn_pulse and dir_held are valid after this edge; dir_last updates at edge D+4.
- Release latency is symmetric: btn_db falls after edge D+3 counted from the first edge sampling 0.
- Bounce handling:
  - Any s reversal before the counter reaches D-1 restarts the debounce from the opposite state.
  - At most one btn_pulse occurs per IDLE→PRESSED excursion.
- Press, release glitch, re-press in WAIT_R: no second pulse.
- Deassert rst synchronously to clk in the system. The block itself tolerates any async assertion.

## Test plan
- DEBOUNCE_CYCLES=4. Reset, then hold btn_raw[3]=1 from edge 1.
  - btn_db[3] and btn_pulse[3] go high after edge 7.
  - btn_pulse[3] goes low after edge 8.
  - dir_held=4'b1000; dir_last=4'b1000 after edge 8.
- Bounce on up: raw pattern 1,0,1,1,0 then steady 1.
  - No pulse until 4 consecutive synced 1s, then exactly one pulse.
  - btn_db[0] stays 0 throughout the bounce.
- Release glitch: while up is held, drop raw for 2 cycles, then restore it.
  - btn_db[0] stays 1 and no new pulse occurs.
  - Then release it steady: btn_db[0] falls 7 edges after the first 0 sample.
- Simultaneous press: btn_raw=4'b0101 on the same edge.
  - btn_pulse=4'b0101 for one cycle.
  - dir_held=4'b0100; dir_last=4'b0100.
- Reset mid-press: assert rst while in PRESSED and also mid-WAIT_P on another channel.
  - All outputs go to 0 without waiting for a clock.
  - After release of rst with buttons still held, the full D+3 latency repeats.
- Sequence: press left, release, then press down.
  - dir_last goes 4'b0100, then stays 4'b0100 through the release, then 4'b0010.
  - dir_held returns to 0 between the two presses.

Source files
------------

// File: rtl/button_conditioner_if.sv
// Button conditioner signal bundle: raw board buttons in, conditioned levels,
// press pulses and resolved directions out.
interface button_conditioner_if;
   logic [3:0] btn_raw;
   logic [3:0] btn_db;
   logic [3:0] btn_pulse;
   logic [3:0] dir_held;
   logic [3:0] dir_last;

   modport master (
      output btn_raw,
      input  btn_db,
      input  btn_pulse,
      input  dir_held,
      input  dir_last
   );

   modport slave (
      input  btn_raw,
      output btn_db,
      output btn_pulse,
      output dir_held,
      output dir_last
   );
endinterface

// File: rtl/button_conditioner.sv
// Four-channel push-button conditioner: two-flop synchronizer, per-channel
// debounce FSM, press pulse, priority-resolved held and last-pressed direction.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic                 clk,
   input  logic                 rst,
   button_conditioner_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_P  = 2'd1,
      PRESSED = 2'd2,
      WAIT_R  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Bit order is [0]=up [1]=down [2]=left [3]=right; priority right>left>up>down.
   function automatic logic [3:0] pri_onehot(input logic [3:0] v);
      logic [3:0] r;
      if (v[3]) begin
         r = 4'b1000;
      end else if (v[2]) begin
         r = 4'b0100;
      end else if (v[0]) begin
         r = 4'b0001;
      end else if (v[1]) begin
         r = 4'b0010;
      end else begin
         r = 4'b0000;
      end
      return r;
   endfunction

   logic [3:0]       sync1_r;
   logic [3:0]       sync2_r;
   state_t           state_r    [4];
   state_t           state_nx_s [4];
   logic [CNT_W-1:0] cnt_r      [4];
   logic [CNT_W-1:0] cnt_nx_s   [4];
   logic [3:0]       pulse_r;
   logic [3:0]       pulse_nx_s;
   logic [3:0]       db_s;
   logic [3:0]       dir_last_r;

   // Two-flop synchronizer for the asynchronous raw buttons.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_r <= 4'b0000;
         sync2_r <= 4'b0000;
      end else begin
         sync1_r <= bus.btn_raw;
         sync2_r <= sync1_r;
      end
   end

   // Debounce next-state: every state entry clears the counter, so it never wraps.
   always_comb begin
      pulse_nx_s = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         state_nx_s[i] = state_r[i];
         cnt_nx_s[i]   = cnt_r[i];
         case (state_r[i])
            IDLE: begin
               if (sync2_r[i]) begin
                  state_nx_s[i] = WAIT_P;
                  cnt_nx_s[i]   = CNT_ZERO;
               end else begin
                  state_nx_s[i] = IDLE;
               end
            end
            WAIT_P: begin
               if (!sync2_r[i]) begin
                  state_nx_s[i] = IDLE;
                  cnt_nx_s[i]   = CNT_ZERO;
               end else if (cnt_r[i] == CNT_MAX) begin
                  state_nx_s[i] = PRESSED;
                  cnt_nx_s[i]   = CNT_ZERO;
                  pulse_nx_s[i] = 1'b1;
               end else begin
                  cnt_nx_s[i]   = cnt_r[i] + CNT_ONE;
               end
            end
            PRESSED: begin
               if (!sync2_r[i]) begin
                  state_nx_s[i] = WAIT_R;
                  cnt_nx_s[i]   = CNT_ZERO;
               end else begin
                  state_nx_s[i] = PRESSED;
               end
            end
            WAIT_R: begin
               if (sync2_r[i]) begin
                  state_nx_s[i] = PRESSED;
                  cnt_nx_s[i]   = CNT_ZERO;
               end else if (cnt_r[i] == CNT_MAX) begin
                  state_nx_s[i] = IDLE;
                  cnt_nx_s[i]   = CNT_ZERO;
               end else begin
                  cnt_nx_s[i]   = cnt_r[i] + CNT_ONE;
               end
            end
            default: begin
               state_nx_s[i] = IDLE;
               cnt_nx_s[i]   = CNT_ZERO;
            end
         endcase
      end
   end

   // Debounce state, counters and the registered press pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            state_r[i] <= IDLE;
            cnt_r[i]   <= CNT_ZERO;
         end
         pulse_r <= 4'b0000;
      end else begin
         for (int i = 0; i < 4; i++) begin
            state_r[i] <= state_nx_s[i];
            cnt_r[i]   <= cnt_nx_s[i];
         end
         pulse_r <= pulse_nx_s;
      end
   end

   // Debounced level decoded straight from the state register.
   always_comb begin
      db_s = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         db_s[i] = (state_r[i] == PRESSED) || (state_r[i] == WAIT_R);
      end
   end

   // Last-pressed direction latches on any cycle carrying a press pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dir_last_r <= 4'b0000;
      end else if (pulse_r != 4'b0000) begin
         dir_last_r <= pri_onehot(pulse_r);
      end else begin
         dir_last_r <= dir_last_r;
      end
   end

   assign bus.btn_db    = db_s;
   assign bus.btn_pulse = pulse_r;
   assign bus.dir_held  = pri_onehot(db_s);
   assign bus.dir_last  = dir_last_r;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4; expected
// values are hand-derived edge counts (press/release land on edge D+3 = 7).
module tb_button_conditioner;

   logic clk;
   logic rst;
   int   total_cnt;
   int   bad_cnt;

   button_conditioner_if bus ();

   button_conditioner #(
      .DEBOUNCE_CYCLES (4),
      .CNT_W           (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
      total_cnt++;
      if (obs !== exp_v) begin
         bad_cnt++;
         $display("FAIL %s: got %b want %b", tag, obs, exp_v);
      end
   endtask

   task automatic check_all(input string tag, input logic [3:0] db, input logic [3:0] pulse,
                            input logic [3:0] held, input logic [3:0] last);
      check_val({tag, ".db"},    bus.btn_db,    db);
      check_val({tag, ".pulse"}, bus.btn_pulse, pulse);
      check_val({tag, ".held"},  bus.dir_held,  held);
      check_val({tag, ".last"},  bus.dir_last,  last);
   endtask

   // Advance n rising edges and settle 2 time units past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      logic [3:0] bounce [5];
      bounce[0] = 4'b0001; bounce[1] = 4'b0000; bounce[2] = 4'b0001;
      bounce[3] = 4'b0001; bounce[4] = 4'b0000;
      total_cnt   = 0;
      bad_cnt     = 0;
      rst         = 1'b1;
      bus.btn_raw = 4'b0000;
      step(2);
      check_all("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      rst = 1'b0;

      // Right held steady from edge 1.
      bus.btn_raw = 4'b1000;
      step(6);
      check_all("right_e6", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      step(1);
      check_all("right_e7", 4'b1000, 4'b1000, 4'b1000, 4'b0000);
      step(1);
      check_all("right_e8", 4'b1000, 4'b0000, 4'b1000, 4'b1000);
      bus.btn_raw = 4'b0000;
      step(6);
      check_all("right_rel_e6", 4'b1000, 4'b0000, 4'b1000, 4'b1000);
      step(1);
      check_all("right_rel_e7", 4'b0000, 4'b0000, 4'b0000, 4'b1000);

      // Bounce on up: 1,0,1,1,0 then steady 1 from edge 6; press lands on edge 12.
      for (int k = 0; k < 5; k++) begin
         bus.btn_raw = bounce[k];
         step(1);
         check_val("bounce.db",    bus.btn_db,    4'b0000);
         check_val("bounce.pulse", bus.btn_pulse, 4'b0000);
      end
      bus.btn_raw = 4'b0001;
      for (int k = 6; k <= 11; k++) begin
         step(1);
         check_val("bounce_settle.db",    bus.btn_db,    4'b0000);
         check_val("bounce_settle.pulse", bus.btn_pulse, 4'b0000);
      end
      step(1);
      check_all("bounce_e12", 4'b0001, 4'b0001, 4'b0001, 4'b1000);
      step(1);
      check_all("bounce_e13", 4'b0001, 4'b0000, 4'b0001, 4'b0001);

      // Release glitch of 2 cycles while up is held: no change, no pulse.
      bus.btn_raw = 4'b0000;
      step(2);
      bus.btn_raw = 4'b0001;
      for (int k = 0; k < 8; k++) begin
         step(1);
         check_all("glitch", 4'b0001, 4'b0000, 4'b0001, 4'b0001);
      end
      bus.btn_raw = 4'b0000;
      step(6);
      check_all("up_rel_e6", 4'b0001, 4'b0000, 4'b0001, 4'b0001);
      step(1);
      check_all("up_rel_e7", 4'b0000, 4'b0000, 4'b0000, 4'b0001);

      // Simultaneous up + left.
      bus.btn_raw = 4'b0101;
      step(6);
      check_all("simul_e6", 4'b0000, 4'b0000, 4'b0000, 4'b0001);
      step(1);
      check_all("simul_e7", 4'b0101, 4'b0101, 4'b0100, 4'b0001);
      step(1);
      check_all("simul_e8", 4'b0101, 4'b0000, 4'b0100, 4'b0100);

      // Down enters WAIT_P, left enters WAIT_R, up stays PRESSED; then async reset.
      bus.btn_raw = 4'b0011;
      step(4);
      check_all("pre_rst", 4'b0101, 4'b0000, 4'b0100, 4'b0100);
      #1;
      rst = 1'b1;
      #1;
      check_all("async_rst", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      step(1);
      rst = 1'b0;
      step(6);
      check_all("post_rst_e6", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      step(1);
      check_all("post_rst_e7", 4'b0011, 4'b0011, 4'b0001, 4'b0000);
      step(1);
      check_all("post_rst_e8", 4'b0011, 4'b0000, 4'b0001, 4'b0001);

      // Sequence: release all, press left, release, press down.
      bus.btn_raw = 4'b0000;
      step(7);
      check_all("seq_rel0", 4'b0000, 4'b0000, 4'b0000, 4'b0001);
      bus.btn_raw = 4'b0100;
      step(7);
      check_all("seq_left_e7", 4'b0100, 4'b0100, 4'b0100, 4'b0001);
      step(1);
      check_all("seq_left_e8", 4'b0100, 4'b0000, 4'b0100, 4'b0100);
      bus.btn_raw = 4'b0000;
      step(7);
      check_all("seq_rel1", 4'b0000, 4'b0000, 4'b0000, 4'b0100);
      bus.btn_raw = 4'b0010;
      step(7);
      check_all("seq_down_e7", 4'b0010, 4'b0010, 4'b0010, 4'b0100);
      step(1);
      check_all("seq_down_e8", 4'b0010, 4'b0000, 4'b0010, 4'b0010);

      // All four together: right wins both resolutions.
      bus.btn_raw = 4'b1111;
      step(7);
      check_all("all_e7", 4'b1111, 4'b1101, 4'b1000, 4'b0010);
      step(1);
      check_all("all_e8", 4'b1111, 4'b0000, 4'b1000, 4'b1000);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
